// File: rtl/prbs_gen_chk_pkg.sv
// Shared constants, encodings and helpers for the PRBS generator/checker.
package prbs_gen_chk_pkg;

  localparam int MAX_LEN = 31;

  // Polynomial select encodings
  typedef enum logic [1:0] {
    POLY_PRBS7  = 2'd0,
    POLY_PRBS15 = 2'd1,
    POLY_PRBS23 = 2'd2,
    POLY_PRBS31 = 2'd3
  } poly_e;

  // Checker state machine
  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } chk_state_e;

  // Loaded instead of an all-zero seed, which would freeze the LFSR
  localparam logic [MAX_LEN-1:0] LOCKUP_GUARD = {MAX_LEN{1'b1}};

  // Register length N of the selected polynomial
  function automatic logic [4:0] poly_len(input logic [1:0] sel);
    case (sel)
      POLY_PRBS7:  poly_len = 5'd7;
      POLY_PRBS15: poly_len = 5'd15;
      POLY_PRBS23: poly_len = 5'd23;
      POLY_PRBS31: poly_len = 5'd31;
      default:     poly_len = 5'd7;
    endcase
  endfunction

  // Second feedback tap T of the selected polynomial
  function automatic logic [4:0] poly_tap(input logic [1:0] sel);
    case (sel)
      POLY_PRBS7:  poly_tap = 5'd6;
      POLY_PRBS15: poly_tap = 5'd14;
      POLY_PRBS23: poly_tap = 5'd18;
      POLY_PRBS31: poly_tap = 5'd28;
      default:     poly_tap = 5'd6;
    endcase
  endfunction

  // Mask selecting the low len bits of the LFSR state (len=31 wraps to all-ones)
  function automatic logic [MAX_LEN-1:0] len_mask(input logic [4:0] len);
    logic [MAX_LEN-1:0] one;
    one = {{(MAX_LEN-1){1'b0}}, 1'b1};
    len_mask = (one << len) - one;
  endfunction

  // Number of received words needed to fill an N-bit checker register
  function automatic logic [5:0] hunt_words(input logic [4:0] len, input int dw);
    hunt_words = 6'((int'(len) + dw - 1) / dw);
  endfunction

endpackage

// File: rtl/prbs_gen_chk_if.sv
// Control, generator and checker signals of the PRBS block.
interface prbs_gen_chk_if
  import prbs_gen_chk_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int ERR_CNT_W = 16
);
  logic                 enable;
  logic [1:0]           poly_sel;
  logic [MAX_LEN-1:0]   seed;
  logic                 inject_err;
  logic [DATA_W-1:0]    gen_data;
  logic                 gen_valid;
  logic [DATA_W-1:0]    chk_data;
  logic                 chk_valid;
  logic                 clr_cnt;
  logic                 locked;
  logic [ERR_CNT_W-1:0] err_cnt;
  logic                 err_sat;

  modport master (
    output enable, poly_sel, seed, inject_err, chk_data, chk_valid, clr_cnt,
    input  gen_data, gen_valid, locked, err_cnt, err_sat
  );

  modport slave (
    input  enable, poly_sel, seed, inject_err, chk_data, chk_valid, clr_cnt,
    output gen_data, gen_valid, locked, err_cnt, err_sat
  );
endinterface

// File: rtl/prbs_gen_chk_lfsr_step.sv
// Combinational DATA_W-bit advance of a Fibonacci LFSR; first bit lands in the word MSB.
module prbs_gen_chk_lfsr_step
  import prbs_gen_chk_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [MAX_LEN-1:0] state,
  input  logic [1:0]         poly_sel,
  output logic [MAX_LEN-1:0] next_state,
  output logic [DATA_W-1:0]  word
);
  logic [4:0]         len_s;
  logic [4:0]         tap_s;
  logic [MAX_LEN-1:0] mask_s;

  assign len_s  = poly_len(poly_sel);
  assign tap_s  = poly_tap(poly_sel);
  assign mask_s = len_mask(len_s);

  // Run DATA_W single-bit steps; each new feedback bit is also the output bit
  always_comb begin
    logic [MAX_LEN-1:0] s;
    logic               nb;
    s    = state;
    nb   = 1'b0;
    word = '0;
    for (int i = 0; i < DATA_W; i++) begin
      nb   = s[len_s - 5'd1] ^ s[tap_s - 5'd1];
      s    = ((s << 1) | MAX_LEN'(nb)) & mask_s;
      word = (word << 1) | DATA_W'(nb);
    end
    next_state = s;
  end
endmodule

// File: rtl/prbs_gen_chk.sv
// PRBS generator plus self-synchronising checker with saturating bit-error counter.
module prbs_gen_chk
  import prbs_gen_chk_pkg::*;
#(
  parameter int DATA_W        = 8,
  parameter int ERR_CNT_W     = 16,
  parameter int LOCK_THRESH   = 4,
  parameter int UNLOCK_THRESH = 4
) (
  input logic           clk,
  input logic           rst,
  prbs_gen_chk_if.slave bus
);
  localparam int GOOD_W = $clog2(LOCK_THRESH + 1);
  localparam int BAD_W  = $clog2(UNLOCK_THRESH + 1);
  localparam int SUM_W  = (ERR_CNT_W + 1 > 7) ? ERR_CNT_W + 1 : 7;
  localparam logic [ERR_CNT_W-1:0] SAT_VAL = {ERR_CNT_W{1'b1}};

  logic [1:0]           poly_r;
  logic [MAX_LEN-1:0]   gen_lfsr_r;
  logic [DATA_W-1:0]    gen_data_r;
  logic                 gen_valid_r;
  logic [MAX_LEN-1:0]   chk_lfsr_r;
  chk_state_e           fsm_r;
  logic [5:0]           hunt_cnt_r;
  logic [GOOD_W-1:0]    good_cnt_r;
  logic [BAD_W-1:0]     bad_cnt_r;
  logic                 locked_r;
  logic [ERR_CNT_W-1:0] err_cnt_r;
  logic                 err_sat_r;

  logic [MAX_LEN-1:0]   seed_mask_s, seed_masked_s, seed_load_s;
  logic [MAX_LEN-1:0]   gen_next_s, pred_state_s, shift_s;
  logic [DATA_W-1:0]    gen_word_s, pred_word_s, diff_s;
  logic [5:0]           hunt_words_s;
  logic [SUM_W-1:0]     pop_s, sum_s;
  logic [ERR_CNT_W-1:0] cnt_next_s;
  logic                 word_err_s;

  prbs_gen_chk_lfsr_step #(.DATA_W(DATA_W)) u_gen_step (
    .state(gen_lfsr_r), .poly_sel(poly_r), .next_state(gen_next_s), .word(gen_word_s)
  );

  prbs_gen_chk_lfsr_step #(.DATA_W(DATA_W)) u_chk_step (
    .state(chk_lfsr_r), .poly_sel(poly_r), .next_state(pred_state_s), .word(pred_word_s)
  );

  // Seed masked to the polynomial being captured this reset; all-zero replaced by the guard
  assign seed_mask_s   = len_mask(poly_len(bus.poly_sel));
  assign seed_masked_s = bus.seed & seed_mask_s;
  assign seed_load_s   = (seed_masked_s == '0) ? (LOCKUP_GUARD & seed_mask_s) : seed_masked_s;

  // Received word shifted straight into the checker register (HUNT/VERIFY seeding)
  assign shift_s      = ((chk_lfsr_r << DATA_W) | MAX_LEN'(bus.chk_data)) & len_mask(poly_len(poly_r));
  assign hunt_words_s = hunt_words(poly_len(poly_r), DATA_W);
  assign diff_s       = pred_word_s ^ bus.chk_data;
  assign word_err_s   = |diff_s;

  // Popcount of the mismatch bits, accumulated wide then clamped so the counter never wraps
  always_comb begin
    logic [DATA_W-1:0] tmp;
    tmp   = diff_s;
    pop_s = '0;
    for (int i = 0; i < DATA_W; i++) begin
      pop_s = pop_s + SUM_W'(tmp[0]);
      tmp   = tmp >> 1;
    end
    sum_s = SUM_W'(err_cnt_r) + pop_s;
    if (sum_s > SUM_W'(SAT_VAL)) begin
      cnt_next_s = SAT_VAL;
    end else begin
      cnt_next_s = sum_s[ERR_CNT_W-1:0];
    end
  end

  // Generator: capture polynomial and seed on reset, then one word per enabled cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      poly_r      <= bus.poly_sel;
      gen_lfsr_r  <= seed_load_s;
      gen_data_r  <= '0;
      gen_valid_r <= 1'b0;
    end else if (bus.enable) begin
      gen_lfsr_r  <= gen_next_s;
      gen_data_r  <= gen_word_s ^ DATA_W'(bus.inject_err);
      gen_valid_r <= 1'b1;
    end else begin
      gen_valid_r <= 1'b0;
    end
  end

  // Checker FSM: seed from data, verify predictions, then free-run while locked
  always_ff @(posedge clk) begin
    if (rst) begin
      chk_lfsr_r <= '0;
      fsm_r      <= HUNT;
      hunt_cnt_r <= 6'd0;
      good_cnt_r <= '0;
      bad_cnt_r  <= '0;
      locked_r   <= 1'b0;
    end else if (bus.chk_valid) begin
      case (fsm_r)
        HUNT: begin
          chk_lfsr_r <= shift_s;
          if (hunt_cnt_r + 6'd1 == hunt_words_s) begin
            fsm_r      <= VERIFY;
            hunt_cnt_r <= 6'd0;
            good_cnt_r <= '0;
          end else begin
            hunt_cnt_r <= hunt_cnt_r + 6'd1;
          end
        end
        VERIFY: begin
          chk_lfsr_r <= shift_s;
          if (!word_err_s) begin
            good_cnt_r <= good_cnt_r + GOOD_W'(1);
            if (good_cnt_r + GOOD_W'(1) == GOOD_W'(LOCK_THRESH)) begin
              fsm_r     <= LOCKED;
              locked_r  <= 1'b1;
              bad_cnt_r <= '0;
            end
          end else begin
            fsm_r      <= HUNT;
            hunt_cnt_r <= 6'd0;
          end
        end
        LOCKED: begin
          // Free-run on the prediction so received errors never corrupt the reference
          chk_lfsr_r <= pred_state_s;
          if (word_err_s) begin
            bad_cnt_r <= bad_cnt_r + BAD_W'(1);
            if (bad_cnt_r + BAD_W'(1) == BAD_W'(UNLOCK_THRESH)) begin
              fsm_r      <= HUNT;
              locked_r   <= 1'b0;
              hunt_cnt_r <= 6'd0;
            end
          end else begin
            bad_cnt_r <= '0;
          end
        end
        default: begin
          fsm_r      <= HUNT;
          locked_r   <= 1'b0;
          hunt_cnt_r <= 6'd0;
        end
      endcase
    end
  end

  // Error counter: clear wins over a same-cycle increment; saturation flag is sticky
  always_ff @(posedge clk) begin
    if (rst || bus.clr_cnt) begin
      err_cnt_r <= '0;
      err_sat_r <= 1'b0;
    end else if (bus.chk_valid && (fsm_r == LOCKED)) begin
      err_cnt_r <= cnt_next_s;
      err_sat_r <= err_sat_r | (cnt_next_s == SAT_VAL);
    end
  end

  assign bus.gen_data  = gen_data_r;
  assign bus.gen_valid = gen_valid_r;
  assign bus.locked    = locked_r;
  assign bus.err_cnt   = err_cnt_r;
  assign bus.err_sat   = err_sat_r;
endmodule
